// File: rtl/spu_hazard_scoreboard.sv
// Register scoreboard and in-order issue gate for the SPU front end: per-register remaining-latency tracking,
// RAW/WAW gating, stall counting. Packed slot buses put slot 0 in the MSBs. Define SPU_SB_FORWARD_EN to forward lat==1 sources.
module spu_hazard_scoreboard #(
    parameter int NUM_PIPES  = 2,
    parameter int PIPE_DEPTH = 7,
    parameter int NUM_REGS   = 128,
    parameter int RA_W       = 7,
    parameter int LAT_W      = 3,
    parameter int NUM_SRC    = 3
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               flush,
    input  logic [NUM_PIPES-1:0]               issue_valid,
    input  logic [NUM_PIPES-1:0]               issue_wr,
    input  logic [NUM_PIPES*RA_W-1:0]          issue_rt,
    input  logic [NUM_PIPES*LAT_W-1:0]         issue_lat,
    input  logic [NUM_PIPES*NUM_SRC-1:0]       src_valid,
    input  logic [NUM_PIPES*NUM_SRC*RA_W-1:0]  src_addr,
    output logic [NUM_PIPES-1:0]               issue_fire,
    output logic                               stall,
    output logic [RA_W:0]                      pending_cnt,
    output logic [15:0]                        stall_cycles
);

`ifdef SPU_SB_FORWARD_EN
    localparam logic [LAT_W-1:0] THR = LAT_W'(1);
`else
    localparam logic [LAT_W-1:0] THR = LAT_W'(0);
`endif
    localparam logic [LAT_W-1:0] MAX_LAT = LAT_W'(PIPE_DEPTH);
    localparam logic [LAT_W-1:0] MIN_LAT = LAT_W'(1);

    logic [LAT_W-1:0] r_lat [NUM_REGS];
    logic [RA_W:0]    r_pending_cnt;
    logic [15:0]      r_stall_cycles;

    logic             w_valid   [NUM_PIPES];
    logic             w_wr      [NUM_PIPES];
    logic [RA_W-1:0]  w_rt      [NUM_PIPES];
    logic [LAT_W-1:0] w_lat_raw [NUM_PIPES];
    logic [LAT_W-1:0] w_lat_eff [NUM_PIPES];
    logic             w_src_v   [NUM_PIPES][NUM_SRC];
    logic [RA_W-1:0]  w_src_a   [NUM_PIPES][NUM_SRC];
    logic             w_ok      [NUM_PIPES];
    logic             w_fire    [NUM_PIPES];
    logic             w_stall;
    logic [LAT_W-1:0] w_lat_next [NUM_REGS];
    logic [RA_W:0]    w_cnt_next;

    genvar gi, gs;

    // Unpack the flat slot buses into per-slot arrays indexed in program order.
    generate
        for (gi = 0; gi < NUM_PIPES; gi++) begin : g_unpack
            localparam int SLOT_BIT = NUM_PIPES - 1 - gi;
            assign w_valid[gi]   = issue_valid[SLOT_BIT];
            assign w_wr[gi]      = issue_wr[SLOT_BIT];
            assign w_rt[gi]      = issue_rt[SLOT_BIT*RA_W +: RA_W];
            assign w_lat_raw[gi] = issue_lat[SLOT_BIT*LAT_W +: LAT_W];
            assign issue_fire[SLOT_BIT] = w_fire[gi];
            for (gs = 0; gs < NUM_SRC; gs++) begin : g_src
                localparam int SRC_BIT = NUM_PIPES*NUM_SRC - 1 - (gi*NUM_SRC + gs);
                assign w_src_v[gi][gs] = src_valid[SRC_BIT];
                assign w_src_a[gi][gs] = src_addr[SRC_BIT*RA_W +: RA_W];
            end
        end
    endgenerate

    generate
        for (gi = 0; gi < NUM_PIPES; gi++) begin : g_slot
            logic w_raw;
            logic w_waw;

            always_comb begin
                w_raw = 1'b0;
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (w_src_v[gi][s]) begin
                        if (r_lat[w_src_a[gi][s]] > THR) begin
                            w_raw = 1'b1;
                        end
                        for (int q = 0; q < gi; q++) begin
                            if (w_valid[q] && w_wr[q] && (w_rt[q] == w_src_a[gi][s])) begin
                                w_raw = 1'b1;
                            end
                        end
                    end
                end
            end

            // WAW always waits for full retirement; forwarding never applies here.
            always_comb begin
                w_waw = 1'b0;
                if (w_wr[gi]) begin
                    if (r_lat[w_rt[gi]] != '0) begin
                        w_waw = 1'b1;
                    end
                    for (int q = 0; q < gi; q++) begin
                        if (w_valid[q] && w_wr[q] && (w_rt[q] == w_rt[gi])) begin
                            w_waw = 1'b1;
                        end
                    end
                end
            end

            assign w_ok[gi] = w_valid[gi] & ~w_raw & ~w_waw;

            assign w_lat_eff[gi] = (w_lat_raw[gi] == '0)               ? MIN_LAT :
                                   (int'(w_lat_raw[gi]) > PIPE_DEPTH) ? MAX_LAT :
                                                                        w_lat_raw[gi];
        end
    endgenerate

    // In-order gate: once any valid slot is held back, every younger slot is held too.
    always_comb begin : p_fire
        logic v_blocked;
        v_blocked = flush;
        w_stall   = 1'b0;
        for (int p = 0; p < NUM_PIPES; p++) begin
            w_fire[p] = w_ok[p] & ~v_blocked;
            if (w_valid[p] && !w_fire[p]) begin
                v_blocked = 1'b1;
                w_stall   = 1'b1;
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [LAT_W-1:0] w_nxt;

            always_comb begin
                w_nxt = (r_lat[gi] != '0) ? (r_lat[gi] - 1'b1) : '0;
                for (int p = 0; p < NUM_PIPES; p++) begin
                    if (w_fire[p] && w_wr[p] && (w_rt[p] == RA_W'(gi))) begin
                        w_nxt = w_lat_eff[p];
                    end
                end
            end

            assign w_lat_next[gi] = w_nxt;
        end
    endgenerate

    always_comb begin
        w_cnt_next = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (w_lat_next[r] != '0) begin
                w_cnt_next = w_cnt_next + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_lat[r] <= '0;
            end
            r_pending_cnt  <= '0;
            r_stall_cycles <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_lat[r] <= w_lat_next[r];
            end
            r_pending_cnt <= w_cnt_next;
            // Flush cycles are not charged as hazard stalls.
            if (w_stall && !flush && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

    assign stall        = w_stall;
    assign pending_cnt  = r_pending_cnt;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_spu_hazard_scoreboard.sv
// Self-checking bench for spu_hazard_scoreboard: directed scenarios plus random traffic against a latency-table model.
module tb_spu_hazard_scoreboard;

    localparam int NP    = 2;
    localparam int NS    = 3;
    localparam int RA_W  = 7;
    localparam int LAT_W = 3;
    localparam int NR    = 128;
    localparam int DEPTH = 7;
`ifdef SPU_SB_FORWARD_EN
    localparam int THR = 1;
`else
    localparam int THR = 0;
`endif

    logic                      clock = 1'b0;
    logic                      reset;
    logic                      flush;
    logic [NP-1:0]             issue_valid;
    logic [NP-1:0]             issue_wr;
    logic [NP*RA_W-1:0]        issue_rt;
    logic [NP*LAT_W-1:0]       issue_lat;
    logic [NP*NS-1:0]          src_valid;
    logic [NP*NS*RA_W-1:0]     src_addr;
    logic [NP-1:0]             issue_fire;
    logic                      stall;
    logic [RA_W:0]             pending_cnt;
    logic [15:0]               stall_cycles;

    spu_hazard_scoreboard dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_wr     (issue_wr),
        .issue_rt     (issue_rt),
        .issue_lat    (issue_lat),
        .src_valid    (src_valid),
        .src_addr     (src_addr),
        .issue_fire   (issue_fire),
        .stall        (stall),
        .pending_cnt  (pending_cnt),
        .stall_cycles (stall_cycles)
    );

    always #5 clock = ~clock;

    // Stimulus in program-order form.
    bit t_flush;
    bit t_valid [NP];
    bit t_wr    [NP];
    int t_rt    [NP];
    int t_lat   [NP];
    bit t_sv    [NP][NS];
    int t_sa    [NP][NS];

    // Model: remaining cycles until each register's value is written back.
    int m_lat [NR];
    int m_stall;
    bit e_fire [NP];
    bit e_stall;

    int n_vec = 0;
    int n_err = 0;

    task automatic cmp(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic clear_stim();
        t_flush = 0;
        for (int p = 0; p < NP; p++) begin
            t_valid[p] = 0; t_wr[p] = 0; t_rt[p] = 0; t_lat[p] = 0;
            for (int s = 0; s < NS; s++) begin
                t_sv[p][s] = 0; t_sa[p][s] = 0;
            end
        end
    endtask

    task automatic pack();
        flush = t_flush;
        for (int p = 0; p < NP; p++) begin
            issue_valid[NP-1-p] = t_valid[p];
            issue_wr[NP-1-p]    = t_wr[p];
            issue_rt[(NP-1-p)*RA_W +: RA_W]   = RA_W'(t_rt[p]);
            issue_lat[(NP-1-p)*LAT_W +: LAT_W] = LAT_W'(t_lat[p]);
            for (int s = 0; s < NS; s++) begin
                src_valid[NP*NS-1-(p*NS+s)] = t_sv[p][s];
                src_addr[(NP*NS-1-(p*NS+s))*RA_W +: RA_W] = RA_W'(t_sa[p][s]);
            end
        end
    endtask

    // A slot may go if its operands are ready, its destination is idle, no older
    // slot in the group touches its registers, and nothing older was held back.
    task automatic predict();
        bit held;
        held    = t_flush;
        e_stall = 0;
        for (int p = 0; p < NP; p++) begin
            bit ok;
            ok = t_valid[p];
            for (int s = 0; s < NS; s++) begin
                if (t_sv[p][s]) begin
                    if (m_lat[t_sa[p][s]] > THR) ok = 0;
                    for (int q = 0; q < p; q++)
                        if (t_valid[q] && t_wr[q] && t_rt[q] == t_sa[p][s]) ok = 0;
                end
            end
            if (t_wr[p]) begin
                if (m_lat[t_rt[p]] != 0) ok = 0;
                for (int q = 0; q < p; q++)
                    if (t_valid[q] && t_wr[q] && t_rt[q] == t_rt[p]) ok = 0;
            end
            e_fire[p] = ok && !held;
            if (t_valid[p] && !e_fire[p]) begin
                held    = 1;
                e_stall = 1;
            end
        end
    endtask

    task automatic compare();
        int ef;
        int pend;
        predict();
        ef = 0;
        for (int p = 0; p < NP; p++) if (e_fire[p]) ef |= (1 << (NP-1-p));
        pend = 0;
        for (int r = 0; r < NR; r++) if (m_lat[r] != 0) pend++;
        cmp("issue_fire", int'(issue_fire), ef);
        cmp("stall", int'(stall), int'(e_stall));
        cmp("pending_cnt", int'(pending_cnt), pend);
        cmp("stall_cycles", int'(stall_cycles), m_stall);
    endtask

    task automatic advance();
        @(posedge clock);
        for (int r = 0; r < NR; r++) if (m_lat[r] > 0) m_lat[r]--;
        for (int p = 0; p < NP; p++) begin
            if (e_fire[p] && t_wr[p])
                m_lat[t_rt[p]] = (t_lat[p] == 0) ? 1 : (t_lat[p] > DEPTH ? DEPTH : t_lat[p]);
        end
        if (e_stall && !t_flush && m_stall < 65535) m_stall++;
        #1;
    endtask

    task automatic step();
        pack();
        #3;
        compare();
        advance();
    endtask

    task automatic run_until(input int slot, input int max_cycles,
                             output int nst, output bit done, output int fv);
        nst = 0; done = 0; fv = 0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            pack();
            #3;
            compare();
            if (issue_fire[NP-1-slot]) begin
                done = 1;
                fv   = int'(issue_fire);
            end else begin
                nst++;
            end
            advance();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  nst;
        bit  done;
        int  fv;
        int  sc0;

        reset = 1'b1;
        clear_stim();
        pack();
        for (int r = 0; r < NR; r++) m_lat[r] = 0;
        m_stall = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        cmp("reset_pending_cnt", int'(pending_cnt), 0);
        cmp("reset_stall_cycles", int'(stall_cycles), 0);
        $display("reset released");

        // RAW on a long-latency result.
        clear_stim();
        t_valid[0] = 1; t_wr[0] = 1; t_rt[0] = 10; t_lat[0] = 6;
        step();
        clear_stim();
        t_valid[0] = 1; t_sv[0][0] = 1; t_sa[0][0] = 10;
        sc0 = int'(stall_cycles);
        run_until(0, 20, nst, done, fv);
        cmp("r10_fired", int'(done), 1);
        cmp("r10_stall_len", nst, 6 - THR);
        cmp("r10_stall_cycles_delta", int'(stall_cycles) - sc0, 6 - THR);
        $display("raw r10: %0d stall cycles", nst);

        // Intra-group RAW.
        clear_stim();
        t_valid[0] = 1; t_wr[0] = 1; t_rt[0] = 3; t_lat[0] = 1;
        t_valid[1] = 1; t_sv[1][0] = 1; t_sa[1][0] = 3;
        pack();
        #3;
        cmp("grp_raw_fire", int'(issue_fire), 2);
        cmp("grp_raw_stall", int'(stall), 1);
        compare();
        advance();
        t_valid[0] = 0; t_wr[0] = 0;
        run_until(1, 10, nst, done, fv);
        cmp("grp_raw_slot1_fired", int'(done), 1);
        $display("intra-group raw r3: slot1 waited %0d", nst);

        // In-order blocking.
        clear_stim();
        t_valid[0] = 1; t_wr[0] = 1; t_rt[0] = 20; t_lat[0] = 3;
        step();
        clear_stim();
        t_valid[0] = 1; t_sv[0][0] = 1; t_sa[0][0] = 20;
        t_valid[1] = 1; t_wr[1] = 1; t_rt[1] = 21; t_lat[1] = 2; t_sv[1][1] = 1; t_sa[1][1] = 22;
        pack();
        #3;
        cmp("inorder_fire", int'(issue_fire), 0);
        compare();
        advance();
        run_until(1, 10, nst, done, fv);
        cmp("inorder_done", int'(done), 1);
        cmp("inorder_both", fv, 3);
        $display("in-order r20: slot1 waited %0d more", nst);

        // Same-destination WAW.
        clear_stim();
        t_valid[0] = 1; t_wr[0] = 1; t_rt[0] = 7; t_lat[0] = 5;
        t_valid[1] = 1; t_wr[1] = 1; t_rt[1] = 7; t_lat[1] = 2;
        pack();
        #3;
        cmp("waw_fire", int'(issue_fire), 2);
        compare();
        advance();
        t_valid[0] = 0; t_wr[0] = 0;
        run_until(1, 10, nst, done, fv);
        cmp("waw_done", int'(done), 1);
        cmp("waw_wait", nst, 5);
        $display("waw r7: slot1 waited %0d", nst);

        // Flush.
        clear_stim();
        t_valid[0] = 1; t_wr[0] = 1; t_rt[0] = 30; t_lat[0] = 4;
        step();
        clear_stim();
        t_flush = 1;
        t_valid[0] = 1; t_wr[0] = 1; t_rt[0] = 40; t_lat[0] = 3;
        t_valid[1] = 1; t_sv[1][0] = 1; t_sa[1][0] = 41;
        sc0 = int'(stall_cycles);
        pack();
        #3;
        cmp("flush_fire", int'(issue_fire), 0);
        compare();
        advance();
        cmp("flush_stall_cycles_held", int'(stall_cycles), sc0);
        $display("flush cycle checked");

        // Random traffic over a small register window to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            clear_stim();
            t_flush = ($urandom_range(15) == 0);
            for (int p = 0; p < NP; p++) begin
                t_valid[p] = ($urandom_range(3) != 0);
                t_wr[p]    = $urandom_range(1);
                t_rt[p]    = ($urandom_range(7) == 0) ? $urandom_range(NR-1) : $urandom_range(15);
                t_lat[p]   = $urandom_range(7);
                for (int s = 0; s < NS; s++) begin
                    t_sv[p][s] = $urandom_range(1);
                    t_sa[p][s] = ($urandom_range(7) == 0) ? $urandom_range(NR-1) : $urandom_range(15);
                end
            end
            step();
        end
        $display("random phase complete");

        // Asynchronous reset mid-run with r5 four cycles from writeback.
        clear_stim();
        t_valid[0] = 1; t_wr[0] = 1; t_rt[0] = 5; t_lat[0] = 7;
        run_until(0, 20, nst, done, fv);
        cmp("r5_write_done", int'(done), 1);
        clear_stim();
        for (int i = 0; i < 3; i++) step();
        #2;
        reset = 1'b1;
        #1;
        cmp("async_reset_pending_cnt", int'(pending_cnt), 0);
        cmp("async_reset_stall_cycles", int'(stall_cycles), 0);
        for (int r = 0; r < NR; r++) m_lat[r] = 0;
        m_stall = 0;
        @(negedge clock);
        reset = 1'b0;
        t_valid[0] = 1; t_sv[0][0] = 1; t_sa[0][0] = 5;
        pack();
        #1;
        cmp("r5_reader_fires", int'(issue_fire), 2);
        #2;
        compare();
        advance();
        $display("async reset checked");

        // Two writers of r7 keep the group stalled every cycle.
        clear_stim();
        t_valid[0] = 1; t_wr[0] = 1; t_rt[0] = 7; t_lat[0] = 7;
        t_valid[1] = 1; t_wr[1] = 1; t_rt[1] = 7; t_lat[1] = 7;
        for (int i = 0; i < 70000; i++) step();
        cmp("stall_cycles_saturated", int'(stall_cycles), 65535);
        $display("saturation checked");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
